// File: rtl/prg_cache.sv
// prg_cache: direct-mapped, read-only instruction cache for the CPU program
// fetch port. A hit returns the word one cycle after the address is presented.
// A miss fills the whole line from external memory, one word per mem_ack, and
// then replays the lookup.
//
// Optional feature: define PRG_CACHE_CWF_EN for critical-word-first fills.
// The fill then starts at the missed word and wraps within the line. When the
// macro is not defined, every fill starts at word 0 of the line.
//
// Ports:
//   clk          clock; all state changes on posedge
//   reset        asynchronous, active-high reset
//   prg_address  word address of the fetch
//   prg_data     instruction word; valid when p_cache_miss = 0
//   p_cache_miss 1 = prg_data not valid, CPU holds prg_address
//   flush        invalidate all lines
//   mem_req      fill word request; held until mem_ack
//   mem_addr     word address of the requested fill word
//   mem_ack      mem_data valid and accepted this cycle
//   mem_data     fill word
module prg_cache #(
  parameter int LINE_LOG2  = 2,
  parameter int LINES_LOG2 = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] prg_address,
  output logic [15:0] prg_data,
  output logic        p_cache_miss,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data
);

  localparam int LINE   = 1 << LINE_LOG2;
  localparam int LINES  = 1 << LINES_LOG2;
  localparam int TAG_W  = 32 - LINES_LOG2 - LINE_LOG2;
  localparam int RAM_AW = LINES_LOG2 + LINE_LOG2;

  typedef enum logic [1:0] {IDLE, FILL, UPDATE, REPLAY} state_t;

  state_t                  state, state_next;
  logic [31:0]             lkp_addr;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [15:0]             data_mem [LINES*LINE];
  logic [LINE_LOG2-1:0]    offset;
  logic [LINE_LOG2-1:0]    count;
  logic                    flush_pending;
  logic [LINE_LOG2-1:0]    start_offset;
  logic [LINES_LOG2-1:0]   lkp_idx;
  logic [TAG_W-1:0]        lkp_tag;
  logic                    hit;
  logic                    last_word;
  logic [RAM_AW-1:0]       rd_addr;

  assign lkp_idx   = lkp_addr[LINE_LOG2 +: LINES_LOG2];
  assign lkp_tag   = lkp_addr[31 -: TAG_W];
  // The full upper address is kept as the tag, so aliasing lines never false-hit.
  assign hit       = valid[lkp_idx] && (tag_mem[lkp_idx] == lkp_tag);
  assign last_word = mem_ack && (&count);

`ifdef PRG_CACHE_CWF_EN
  assign start_offset = lkp_addr[LINE_LOG2-1:0];
`else
  assign start_offset = '0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!hit) state_next = FILL;
      FILL:    if (last_word) state_next = UPDATE;
      UPDATE:  state_next = REPLAY;
      REPLAY:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. The low bits of the line base are zero, so the fill address is a
  // concatenation of the line base and the word offset.
  always_comb begin
    p_cache_miss = 1'b1;
    mem_req      = 1'b0;
    mem_addr     = '0;
    case (state)
      IDLE: p_cache_miss = ~hit;
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {lkp_addr[31:LINE_LOG2], offset};
      end
      default: ;
    endcase
  end

  // Lookup address, fill counters, and valid bits.
  // lkp_addr only advances on a hit in IDLE, so it stays frozen while a miss
  // is being serviced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lkp_addr      <= '0;
      offset        <= '0;
      count         <= '0;
      flush_pending <= 1'b0;
      valid         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            lkp_addr <= prg_address;
          end else begin
            offset        <= start_offset;
            count         <= '0;
            flush_pending <= 1'b0;
          end
        end
        FILL: begin
          if (mem_ack) begin
            offset <= offset + 1'b1;
            count  <= count + 1'b1;
          end
          if (flush) flush_pending <= 1'b1;
        end
        default: ;
      endcase
      // A flush at any point during the fill keeps the new line invalid, so the
      // replay misses and the line is fetched again.
      if (flush)
        valid <= '0;
      else if (state == UPDATE && !flush_pending)
        valid[lkp_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == UPDATE) tag_mem[lkp_idx] <= lkp_tag;
  end

  always_ff @(posedge clk) begin
    if (state == FILL && mem_ack) data_mem[{lkp_idx, offset}] <= mem_data;
  end

  // On a hit in IDLE, read the next fetch. Otherwise, re-read the frozen
  // lookup address; UPDATE and REPLAY use this path to deliver the replay data.
  assign rd_addr = (state == IDLE && hit) ? prg_address[RAM_AW-1:0]
                                          : lkp_addr[RAM_AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prg_data <= '0;
    else       prg_data <= data_mem[rd_addr];
  end

endmodule

// File: tb/tb_prg_cache.sv
// tb_prg_cache: scoreboard bench for prg_cache. The driver issues fetches and
// pushes them into a queue. A separate monitor pops each fetch when
// p_cache_miss drops and compares the following against a direct-mapped cache
// model and a synthetic memory:
//   - the data returned,
//   - the number of fill words,
//   - the fill address order,
//   - the latency.
module tb_prg_cache;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] prg_address = '0;
  logic [15:0] prg_data;
  logic        p_cache_miss;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;

  always #5 clk = ~clk;

  prg_cache dut (
    .clk(clk), .reset(reset), .prg_address(prg_address), .prg_data(prg_data),
    .p_cache_miss(p_cache_miss), .flush(flush), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
  );

  typedef struct {
    logic [31:0] addr;
    bit          flush_before;
  } fetch_t;

  fetch_t      sb_q[$];
  logic [31:0] fill_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_ack_cyc = 0;
  bit          midfill_flag = 0;
  bit          mvalid[64];
  logic [23:0] mtag[64];

  function automatic logic [15:0] mem_model(input logic [31:0] a);
    if (a < 32'd4) return 16'h1111 * (a[15:0] + 16'd1);
    return (a[15:0] * 16'h2F1B) ^ a[31:16] ^ 16'hA5C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mvalid[i] = 0;
  endtask

  // Monitor: the fetch at the head of the queue completes when miss drops.
  initial begin
    int wait_c = 0;
    fetch_t f;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        wait_c = 0;
        continue;
      end
      if (sb_q.size() == 0) continue;
      if (p_cache_miss) begin
        wait_c++;
        if (wait_c == 300) begin
          n_cmp++;
          n_bad++;
          $display("FAIL fetch_timeout: addr 0x%08h still missing after 300 cycles", sb_q[0].addr);
        end
        continue;
      end
      begin
        int idx, start, nlines;
        bit exp_hit;
        logic [23:0] tg;
        logic [31:0] base;
        f = sb_q.pop_front();
        idx = int'(f.addr[7:2]);
        tg = f.addr[31:8];
        base = {f.addr[31:2], 2'b00};
`ifdef PRG_CACHE_CWF_EN
        start = int'(f.addr[1:0]);
`else
        start = 0;
`endif
        if (f.flush_before || midfill_flag) clear_model();
        exp_hit = mvalid[idx] && (mtag[idx] == tg);
        nlines = exp_hit ? 0 : (midfill_flag ? 2 : 1);
        check("data", {16'h0, prg_data}, {16'h0, mem_model(f.addr)});
        check("fill_words", fill_q.size(), nlines * 4);
        for (int k = 0; k < fill_q.size(); k++)
          check("fill_addr", fill_q[k], base + 32'((start + k) % 4));
        if (exp_hit) check("hit_latency", wait_c, 0);
        else         check("miss_to_data", cyc - last_ack_cyc, 3);
        $display("fetch addr=0x%08h data=0x%04h hit=%0b fills=%0d", f.addr, prg_data, exp_hit, fill_q.size());
        fill_q.delete();
        mvalid[idx] = 1;
        mtag[idx] = tg;
        midfill_flag = 0;
        wait_c = 0;
      end
    end
  end

  // Memory responder: random ack timing and occasional spurious acks while idle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && mem_req && $urandom_range(0, 3) != 0) begin
        mem_ack = 1'b1;
        mem_data = mem_model(mem_addr);
        fill_q.push_back(mem_addr);
        last_ack_cyc = cyc;
      end else if (!reset && !mem_req && $urandom_range(0, 7) == 0) begin
        mem_ack = 1'b1;
        mem_data = 16'hDEAD;
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  // Issue one fetch on the next edge that accepts a new address.
  task automatic issue(input logic [31:0] a, input bit fl);
    int t = 0;
    forever begin
      @(negedge clk);
      #1;
      flush = 1'b0;
      if (!p_cache_miss) break;
      t++;
      if (t > 400) begin
        n_cmp++;
        n_bad++;
        $display("FAIL issue_timeout: could not issue 0x%08h", a);
        break;
      end
    end
    prg_address = a;
    flush = fl;
    sb_q.push_back(fetch_t'{addr: a, flush_before: fl});
  endtask

  task automatic wait_fill(input int n);
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      flush = 1'b0;
      t++;
    end while (fill_q.size() < n && t < 400);
    if (fill_q.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fill_timeout: %0d fill words seen, wanted %0d", fill_q.size(), n);
    end
  endtask

  initial begin
    logic [31:0] hi [4];
    hi[0] = 32'h0;
    hi[1] = 32'h100;
    hi[2] = 32'h12345600;
    hi[3] = 32'hFFFFFF00;
    clear_model();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_miss", {31'h0, p_cache_miss}, 32'h1);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_prg_data", {16'h0, prg_data}, 32'h0);
    reset = 1'b0;
    sb_q.push_back(fetch_t'{addr: 32'h0, flush_before: 1'b0});

    // Sequential hits, alias miss, refetch.
    issue(32'h1, 0);
    issue(32'h2, 0);
    issue(32'h3, 0);
    issue(32'h100, 0);
    issue(32'h0, 0);
    // Flush after the second fill word: the line must be fetched twice.
    issue(32'h40, 0);
    wait_fill(2);
    flush = 1'b1;
    midfill_flag = 1;
    // Flush while idle, then fetch of 0 must miss.
    issue(32'h0, 1);
    issue(32'h6, 0);
    // Reset after one fill word.
    issue(32'h80, 0);
    wait_fill(1);
    reset = 1'b1;
    #1;
    check("rstfill_mem_req", {31'h0, mem_req}, 32'h0);
    check("rstfill_miss", {31'h0, p_cache_miss}, 32'h1);
    sb_q.delete();
    fill_q.delete();
    clear_model();
    midfill_flag = 0;
    prg_address = 32'h0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    sb_q.push_back(fetch_t'{addr: 32'h0, flush_before: 1'b0});
    issue(32'h80, 0);

    // Random fetches over a few tags.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = hi[$urandom_range(0, 3)] | 32'($urandom_range(0, 63));
      issue(a, $urandom_range(0, 19) == 0);
    end

    // Drain the scoreboard.
    begin
      int t = 0;
      while (sb_q.size() != 0 && t < 500) begin
        @(negedge clk);
        #1;
        flush = 1'b0;
        t++;
      end
      if (sb_q.size() != 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout: %0d fetches outstanding", sb_q.size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
